// File: rtl/mac_window_accum_pkg.sv
// Shared constants, width helper and output-register state type for the
// windowed accumulator that follows the 8-bit multiply-add pipeline.
package mac_window_accum_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned WIN_LOG2_DEF = 2;
  localparam int unsigned WIN_LOG2_MAX = 8;

  // Exact width for 2^win_log2 unsigned samples of data_w bits.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned win_log2);
    return data_w + win_log2;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } outreg_state_t;

endpackage

// File: rtl/mac_window_accum_if.sv
// Sample-in / window-result-out bundle for mac_window_accum.
interface mac_window_accum_if #(
  parameter int unsigned DATA_W   = mac_window_accum_pkg::DATA_W_DEF,
  parameter int unsigned WIN_LOG2 = mac_window_accum_pkg::WIN_LOG2_DEF
);

  localparam int unsigned SUM_W = mac_window_accum_pkg::sum_width(DATA_W, WIN_LOG2);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_mean;
  logic              out_valid;
  logic              out_ready;

  // Producer of samples / consumer of results.
  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_sum, out_mean, out_valid
  );

  // The accumulator itself.
  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_sum, out_mean, out_valid
  );

endinterface

// File: rtl/mac_window_outreg.sv
// One-entry valid/ready holding register; a load while full is a reload
// that replaces the entry being consumed on the same edge.
module mac_window_outreg
  import mac_window_accum_pkg::*;
#(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] data,
  output logic         full
);

  outreg_state_t state;

  // State and payload; the payload only moves on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
            data  <= load_data;
          end
        end
        FULL: begin
          if (load) begin
            data <= load_data;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == FULL);
  assign full      = (state == FULL);

endmodule

// File: rtl/mac_window_accum.sv
// Sums fixed windows of 2^WIN_LOG2 samples and presents sum and truncated
// mean through a one-entry output register; stalls only a completing sample.
module mac_window_accum
  import mac_window_accum_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_window_accum_if.slave   bus
);

  localparam int unsigned SUM_W   = sum_width(DATA_W, WIN_LOG2);
  localparam int unsigned N       = 32'd1 << WIN_LOG2;
  localparam int unsigned CNT_W   = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam int unsigned RES_W   = SUM_W + DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [SUM_W-1:0]  sum_next_c;
  logic [DATA_W-1:0] mean_next_c;
  logic              last_c;
  logic              accept_c;
  logic              load_c;
  logic              full;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;

  // With a one-sample window cnt stays at zero, so every sample is last.
  assign last_c      = (cnt == LAST_CNT);
  assign sum_next_c  = acc + SUM_W'(bus.in_data);
  assign mean_next_c = DATA_W'(sum_next_c >> WIN_LOG2);

  assign bus.in_ready = !bus.clear && !(full && !bus.out_ready && last_c);
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign load_c       = accept_c && last_c;

  // Partial-window state; clear wins and blocks acceptance that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      if (last_c) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_next_c;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  mac_window_outreg #(
    .W (RES_W)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .load_data ({mean_next_c, sum_next_c}),
    .out_ready (bus.out_ready),
    .out_valid (res_valid),
    .data      (res_data),
    .full      (full)
  );

  assign bus.out_valid = res_valid;
  assign bus.out_sum   = res_data[SUM_W-1:0];
  assign bus.out_mean  = res_data[RES_W-1:SUM_W];

endmodule

// File: tb/tb_mac_window_accum.sv
// Directed and random checks of mac_window_accum against a sample-list model.
module tb_mac_window_accum;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WIN_LOG2 = 2;
  localparam int          N        = 1 << WIN_LOG2;

  logic clk;
  logic rst_n;

  mac_window_accum_if #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) bus ();

  mac_window_accum #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: samples of the open window, plus the held result.
  int   win[$];
  logic m_valid = 1'b0;
  int   m_sum   = 0;
  int   m_mean  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, "_sum"},   32'(bus.out_sum),   32'(m_sum));
    chk({tag, "_mean"},  32'(bus.out_mean),  32'(m_mean));
  endtask

  // One cycle: drive after negedge, check in_ready, update model at posedge, check outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    logic exp_rdy;
    bit   done;
    int   s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.clear     = c;
    bus.out_ready = r;
    #1;
    exp_rdy = !c && !(m_valid && !r && (win.size() == N - 1));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    done = 1'b0;
    if (c) begin
      win.delete();
    end else if (v && exp_rdy) begin
      win.push_back(int'(d));
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_sum   = s;
        m_mean  = s / N;
        m_valid = 1'b1;
        done    = 1'b1;
        win.delete();
      end
    end
    if (!done && r) m_valid = 1'b0;
    #1;
    chk_out("out");
    @(negedge clk);
  endtask

  // Reset pulse between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    win.delete();
    m_valid = 1'b0;
    m_sum   = 0;
    m_mean  = 0;
    chk_out("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset");
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Basic window
    step(1'b1, 8'd10, 1'b0, 1'b1);
    step(1'b1, 8'd20, 1'b0, 1'b1);
    step(1'b1, 8'd30, 1'b0, 1'b1);
    step(1'b1, 8'd40, 1'b0, 1'b1);
    chk("basic_sum", 32'(bus.out_sum), 32'd100);
    chk("basic_mean", 32'(bus.out_mean), 32'd25);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("basic_drain", 32'(bus.out_valid), 32'd0);

    // Max values, then truncating mean
    for (int i = 0; i < 4; i++) step(1'b1, 8'd255, 1'b0, 1'b1);
    chk("max_sum", 32'(bus.out_sum), 32'd1020);
    chk("max_mean", 32'(bus.out_mean), 32'd255);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd2, 1'b0, 1'b1);
    chk("trunc_sum", 32'(bus.out_sum), 32'd5);
    chk("trunc_mean", 32'(bus.out_mean), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Backpressure: second window's last sample stalls until out_ready
    for (int i = 0; i < 7; i++) step(1'b1, 8'd1, 1'b0, 1'b0);
    chk("bp_held", 32'(bus.out_sum), 32'd4);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    chk("bp_reload_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_reload_sum", 32'(bus.out_sum), 32'd4);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Clear mid-window
    step(1'b1, 8'd50, 1'b0, 1'b1);
    step(1'b1, 8'd60, 1'b0, 1'b1);
    step(1'b1, 8'd99, 1'b1, 1'b1);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd2, 1'b0, 1'b1);
    step(1'b1, 8'd3, 1'b0, 1'b1);
    step(1'b1, 8'd4, 1'b0, 1'b1);
    chk("clr_sum", 32'(bus.out_sum), 32'd10);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Clear while holding a result
    step(1'b1, 8'd10, 1'b0, 1'b0);
    step(1'b1, 8'd20, 1'b0, 1'b0);
    step(1'b1, 8'd30, 1'b0, 1'b0);
    step(1'b1, 8'd40, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("clr_full_sum", 32'(bus.out_sum), 32'd100);
    chk("clr_full_valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Async reset while full and mid-window
    for (int i = 0; i < 6; i++) step(1'b1, 8'd7, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd4, 1'b0, 1'b1);
    chk("post_rst_sum", 32'(bus.out_sum), 32'd16);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step(logic'($urandom_range(0, 3) != 0),
             8'($urandom_range(0, 255)),
             logic'($urandom_range(0, 19) == 0),
             logic'($urandom_range(0, 2) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_window_accum.md
# mac_window_accum

Downstream stage for the 8-bit multiply-add pipeline. Consumes the pipeline's result stream one sample per accepted handshake and sums fixed windows of 2^WIN_LOG2 consecutive samples. Presents each window's full-precision sum and truncated mean through a one-entry valid/ready output register. Applies backpressure only when a completed window has nowhere to go.

## Interface
Parameters:
- DATA_W, 8, width of each input sample (unsigned)
- WIN_LOG2, 2, log2 of window length; window length N = 2^WIN_LOG2, legal range 0..8
- SUM_W, DATA_W+WIN_LOG2, sum width; derived, never overridden

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W  unsigned sample
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block accepts in_data this cycle
- clear  in  1  synchronous flush of the partial window
- out_sum  out  SUM_W  sum of the last completed window
- out_mean  out  DATA_W  out_sum >> WIN_LOG2 (truncating)
- out_valid  out  1  out_sum/out_mean hold an unconsumed result
- out_ready  in  1  consumer takes the result this cycle

## Operation
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Internal state:
  - acc[SUM_W-1:0], the partial sum.
  - cnt[WIN_LOG2-1:0], samples in the current window. For WIN_LOG2=0, cnt is absent and every sample is a last sample.
- Output register state machine:
  - States are EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL when a window completes.
  - FULL -> EMPTY on an output transfer with no completion in the same cycle.
  - FULL stays FULL with a reload when an output transfer and a completion coincide.
- Non-last sample (cnt != N-1): acc <= acc + in_data; cnt <= cnt + 1.
- Last sample (cnt == N-1), i.e. window completion:
  - out_sum <= acc + in_data; out_mean <= (acc + in_data) >> WIN_LOG2.
  - acc <= 0; cnt <= 0 (wrap).
- Width: SUM_W is exact for N samples of DATA_W bits, so overflow is impossible and there is no saturation logic.
- in_ready = !clear & !(out_valid & !out_ready & cnt == N-1).
  - Non-last samples are always accepted, even while FULL.
  - Only a completing sample stalls, and only while the held result is not being consumed that cycle.
- clear:
  - acc <= 0, cnt <= 0, and in_ready=0 for that cycle, so no sample is accepted.
  - The held output and out_valid are unaffected.
- out_sum and out_mean change only on a completion load. They are stable while out_valid=1 and out_ready=0.

## Timing
- Reset: acc=0, cnt=0, out_sum=0, out_mean=0, out_valid=0. in_ready reads 1 once rst_n is high and clear is low.
- Reset asserted mid-window discards the partial window and any held result immediately, asynchronously.
- Latency: last sample accepted at edge t gives out_valid=1 and the new result visible after edge t, i.e. 1 cycle.
- Throughput: one sample per cycle sustained when out_ready=1. One result per N cycles.
- Same-edge completion and output transfer: the old result is consumed, the new result is loaded, out_valid stays 1, and nothing is lost.
- in_ready has a combinational path from out_ready and clear. out_valid, out_sum and out_mean are registered.
- in_data is ignored when in_valid=0.

## Structure
- Package mac_window_accum_pkg holds:
  - default DATA_W and WIN_LOG2 constants;
  - the function sum_width(data_w, win_log2);
  - the typedef for the FSM state (EMPTY, FULL).
- One sub-module: mac_window_outreg, a one-entry valid/ready holding register (load, load_data, out_ready -> out_valid, data, full). The top level keeps acc, cnt, in_ready and clear logic.

## Test plan
- Basic window (WIN_LOG2=2, out_ready=1): samples 10,20,30,40 back-to-back -> out_valid one cycle after 40; out_sum=100; out_mean=25; then out_valid=0.
- Max values: four samples of 255 -> out_sum=1020 (10 bits), out_mean=255. Then samples 1,1,1,2 -> out_sum=5, out_mean=1 (truncation).
- Backpressure with out_ready=0 and 8 samples of value 1:
  - the first window completes and out_valid=1, out_sum=4;
  - samples 5-7 are accepted;
  - the 8th sample sees in_ready=0 until out_ready pulses;
  - on that edge the 8th sample is accepted, out_valid stays 1, and out_sum=4 is replaced by the second window's 4.
- Clear mid-window: samples 50,60, then clear for 1 cycle with in_valid=1 -> in_ready=0 during clear, partial window dropped; then 1,2,3,4 -> out_sum=10.
- Clear while FULL: out_valid=1 holding 100, clear pulsed -> out_sum=100 and out_valid=1 unchanged until out_ready.
- Async reset mid-window and while FULL: rst_n low between edges -> out_valid, out_sum, out_mean drop to 0 immediately; after release, 4,4,4,4 -> out_sum=16, with no stale partial sum included.
